// File: rtl/gfx_mem_responder_pkg.sv
`default_nettype none
// =============================================================================
// Module   : gfx_mem_pkg
// Purpose  : Shared port indices and the read-tag type for gfx_mem_responder.
// Revision : 1.0
// =============================================================================
package gfx_mem_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_BITS = 2;

    localparam logic [PORT_BITS-1:0] PORT_SPCON = 2'd0;
    localparam logic [PORT_BITS-1:0] PORT_BG0   = 2'd1;
    localparam logic [PORT_BITS-1:0] PORT_BG1   = 2'd2;
    localparam logic [PORT_BITS-1:0] PORT_OV    = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic [PORT_BITS-1:0] port;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/gfx_mem_responder_rr_arbiter4.sv
`default_nettype none
// =============================================================================
// Module   : rr_arbiter4
// Purpose  : Four-way round-robin arbiter; search begins at ptr.
// Revision : 1.0
// =============================================================================
module rr_arbiter4
    import gfx_mem_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 en,
    input  logic [PORT_BITS-1:0] ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PORT_BITS-1:0] gnt_idx,
    output logic [PORT_BITS-1:0] ptr_next
);

    logic [PORT_BITS-1:0] w_idx;
    logic                 w_found;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        ptr_next = ptr;
        w_found  = 1'b0;
        w_idx    = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // Index arithmetic wraps naturally in PORT_BITS bits.
            w_idx = ptr + PORT_BITS'(k);
            if (en && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
                ptr_next   = w_idx + PORT_BITS'(1);
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gfx_mem_responder.sv
`default_nettype none
// =============================================================================
// Module   : gfx_mem_responder
// Purpose  : Arbitrates four gfx read requesters onto a fixed-latency memory port.
// Revision : 1.0
// =============================================================================
module gfx_mem_responder
    import gfx_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 16,
    parameter int MEM_LATENCY = 2
)(
    input  logic                 CLK,
    input  logic                 RSTb,

    input  logic [ADDR_BITS-1:0] spcon_memory_address,
    input  logic                 spcon_rvalid,
    output logic [DATA_BITS-1:0] spcon_memory_data,
    output logic                 spcon_rready,

    input  logic [ADDR_BITS-1:0] bg0_memory_address,
    input  logic                 bg0_rvalid,
    output logic [DATA_BITS-1:0] bg0_memory_data,
    output logic                 bg0_rready,

    input  logic [ADDR_BITS-1:0] bg1_memory_address,
    input  logic                 bg1_rvalid,
    output logic [DATA_BITS-1:0] bg1_memory_data,
    output logic                 bg1_rready,

    input  logic [ADDR_BITS-1:0] ov_memory_address,
    input  logic                 ov_rvalid,
    output logic [DATA_BITS-1:0] ov_memory_data,
    output logic                 ov_rready,

    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_rd,
    input  logic [DATA_BITS-1:0] mem_data,
    input  logic                 mem_ready
);

    logic [ADDR_BITS-1:0] w_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_rvalid;
    logic [NUM_PORTS-1:0] w_eligible;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [PORT_BITS-1:0] w_gnt_idx;
    logic [PORT_BITS-1:0] w_ptr_next;
    logic                 w_any;
    tag_t                 w_tail;

    logic [NUM_PORTS-1:0] r_busy;
    logic [NUM_PORTS-1:0] r_rready;
    logic [PORT_BITS-1:0] r_rr_ptr;
    logic [DATA_BITS-1:0] r_data [NUM_PORTS];
    tag_t                 r_tag  [MEM_LATENCY+1];

    assign w_addr[PORT_SPCON] = spcon_memory_address;
    assign w_addr[PORT_BG0]   = bg0_memory_address;
    assign w_addr[PORT_BG1]   = bg1_memory_address;
    assign w_addr[PORT_OV]    = ov_memory_address;

    assign w_rvalid   = {ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};
    assign w_eligible = w_rvalid & ~r_busy;
    assign w_any      = |w_gnt;
    assign w_tail     = r_tag[MEM_LATENCY];

    rr_arbiter4 u_arb (
        .req      (w_eligible),
        .en       (mem_ready),
        .ptr      (r_rr_ptr),
        .gnt      (w_gnt),
        .gnt_idx  (w_gnt_idx),
        .ptr_next (w_ptr_next)
    );

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_rr_ptr    <= '0;
            r_busy      <= '0;
            r_rready    <= '0;
            mem_rd      <= 1'b0;
            mem_address <= '0;
            for (int i = 0; i <= MEM_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_rr_ptr <= w_ptr_next;
            // A port stays busy through its rready cycle so a held rvalid is not re-granted.
            r_busy   <= (r_busy | w_gnt) & ~r_rready;
            mem_rd   <= w_any;
            if (w_any) begin
                mem_address <= w_addr[w_gnt_idx];
            end

            r_tag[0] <= '{valid: w_any, port: w_gnt_idx};
            for (int i = 1; i <= MEM_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end

            r_rready <= '0;
            if (w_tail.valid) begin
                r_data[w_tail.port]   <= mem_data;
                r_rready[w_tail.port] <= 1'b1;
            end
        end
    end

    assign spcon_memory_data = r_data[PORT_SPCON];
    assign bg0_memory_data   = r_data[PORT_BG0];
    assign bg1_memory_data   = r_data[PORT_BG1];
    assign ov_memory_data    = r_data[PORT_OV];

    assign spcon_rready = r_rready[PORT_SPCON];
    assign bg0_rready   = r_rready[PORT_BG0];
    assign bg1_rready   = r_rready[PORT_BG1];
    assign ov_rready    = r_rready[PORT_OV];

endmodule
`default_nettype wire

// File: tb/tb_gfx_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for gfx_mem_responder: fixed-latency memory model plus per-port response scoreboard.
module tb_gfx_mem_responder;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          CLK = 1'b0;
    logic          RSTb;
    logic          mem_ready;
    logic [AW-1:0] addr [4];
    logic [3:0]    rv;
    logic [DW-1:0] dout [4];
    logic [3:0]    rdy;
    logic [AW-1:0] mem_address;
    logic          mem_rd;
    logic [DW-1:0] mem_data;

    gfx_mem_responder #(.ADDR_BITS(AW), .DATA_BITS(DW), .MEM_LATENCY(LAT)) dut (
        .CLK                  (CLK),
        .RSTb                 (RSTb),
        .spcon_memory_address (addr[0]),
        .spcon_rvalid         (rv[0]),
        .spcon_memory_data    (dout[0]),
        .spcon_rready         (rdy[0]),
        .bg0_memory_address   (addr[1]),
        .bg0_rvalid           (rv[1]),
        .bg0_memory_data      (dout[1]),
        .bg0_rready           (rdy[1]),
        .bg1_memory_address   (addr[2]),
        .bg1_rvalid           (rv[2]),
        .bg1_memory_data      (dout[2]),
        .bg1_rready           (rdy[2]),
        .ov_memory_address    (addr[3]),
        .ov_rvalid            (rv[3]),
        .ov_memory_data       (dout[3]),
        .ov_rready            (rdy[3]),
        .mem_address          (mem_address),
        .mem_rd               (mem_rd),
        .mem_data             (mem_data),
        .mem_ready            (mem_ready)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 16'h1234) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Memory: word for a mem_rd in cycle c is presented in cycle c+LAT, garbage otherwise.
    logic [DW-1:0] mp0, mp1;
    always @(posedge CLK) begin
        mp0 <= (mem_rd === 1'b1) ? mem_fn(mem_address) : 16'hDEAD;
        mp1 <= mp0;
    end
    assign mem_data = mp1;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          expq[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            rd_cnt = 0;
    int            cnt_a = 0;
    int            cnt_b = 0;
    int            alt_err = 0;
    int            rereq_left [4];
    bit            timed;
    bit            fair_mode;
    logic [AW-1:0] last_rd_addr;
    logic [3:0]    prev_rv;
    logic [3:0]    prev_rdy;
    logic          prev_rst;

    function automatic void push(input int p, input logic [DW-1:0] d, input int c);
        exp_t e;
        e.port = p;
        e.data = d;
        e.cyc  = c;
        expq.push_back(e);
    endfunction

    // One clock cycle: scoreboard responses mid-cycle, then advance and update requesters.
    task automatic tick();
        logic [3:0] seen;
        int         idx;
        @(negedge CLK);
        seen = rdy;
        total++;
        if ($countones(seen) > 1) begin
            bad++;
            $display("FAIL rready_onehot cycle %0d: got %b want at most one bit", cyc, seen);
        end
        for (int i = 0; i < 4; i++) begin
            if (seen[i] === 1'b1) begin
                idx = -1;
                for (int k = 0; k < expq.size(); k++) begin
                    if (idx < 0 && expq[k].port == i) idx = k;
                end
                total++;
                if (idx < 0) begin
                    bad++;
                    $display("FAIL unexpected_rready port %0d cycle %0d: got 1 want 0", i, cyc);
                end else begin
                    if (dout[i] !== expq[idx].data) begin
                        bad++;
                        $display("FAIL resp_data port %0d: got %h want %h", i, dout[i], expq[idx].data);
                    end
                    if (expq[idx].cyc >= 0) begin
                        total++;
                        if (cyc != expq[idx].cyc) begin
                            bad++;
                            $display("FAIL resp_cycle port %0d: got %0d want %0d", i, cyc, expq[idx].cyc);
                        end
                    end
                    expq.delete(idx);
                end
            end
            if (prev_rst && RSTb && prev_rv[i] && !rv[i] && !prev_rdy[i]) begin
                bad++;
                $display("FAIL rvalid_contract port %0d: got dropped want held until rready", i);
            end
        end
        if (mem_rd === 1'b1) begin
            rd_cnt++;
            if (mem_address == 16'h0200) cnt_a++;
            if (mem_address == 16'h0202) cnt_b++;
            if (fair_mode && mem_address == last_rd_addr) alt_err++;
            last_rd_addr = mem_address;
        end
        prev_rv  = rv;
        prev_rdy = seen;
        prev_rst = RSTb;
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (seen[i] === 1'b1) begin
                if (rereq_left[i] > 0) begin
                    rereq_left[i]--;
                    push(i, mem_fn(addr[i]), timed ? cyc + 4 : -1);
                end else begin
                    rv[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        RSTb      = 1'b0;
        rv        = 4'b0;
        mem_ready = 1'b1;
        timed     = 1'b1;
        fair_mode = 1'b0;
        for (int i = 0; i < 4; i++) rereq_left[i] = 0;
        tick();
        tick();
        expq.delete();
        RSTb = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        RSTb      = 1'b0;
        rv        = 4'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        total++;
        if (rdy !== 4'b0) begin
            bad++;
            $display("FAIL reset_rready: got %b want 0000", rdy);
        end
        total++;
        if (mem_rd !== 1'b0 || mem_address !== 16'h0) begin
            bad++;
            $display("FAIL reset_mem: got rd=%b addr=%h want rd=0 addr=0000", mem_rd, mem_address);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dout[i] !== 16'h0) begin
                bad++;
                $display("FAIL reset_data port %0d: got %h want 0000", i, dout[i]);
            end
        end
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        t0 = cyc;
        addr[1] = 16'h1234;
        rv[1]   = 1'b1;
        push(1, 16'hBEEF, t0 + 4);
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_address !== 16'h1234) begin
            bad++;
            $display("FAIL single_issue: got rd=%b addr=%h want rd=1 addr=1234", mem_rd, mem_address);
        end
        repeat (6) tick();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL single_pending: got %0d outstanding want 0", expq.size());
        end
        total++;
        if (dout[1] !== 16'hBEEF) begin
            bad++;
            $display("FAIL single_hold: got %h want beef", dout[1]);
        end
    endtask

    task automatic test_all_ports();
        int t0;
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            addr[i] = 16'h0010 + 16'(i);
            push(i, mem_fn(16'h0010 + 16'(i)), t0 + 4 + i);
        end
        rv = 4'hF;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (mem_rd !== 1'b1 || mem_address !== 16'h0010 + 16'(c)) begin
                bad++;
                $display("FAIL all_issue slot %0d: got rd=%b addr=%h want rd=1 addr=%h",
                         c, mem_rd, mem_address, 16'h0010 + 16'(c));
            end
        end
        repeat (6) tick();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL all_pending: got %0d outstanding want 0", expq.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dout[i] !== mem_fn(16'h0010 + 16'(i))) begin
                bad++;
                $display("FAIL all_hold port %0d: got %h want %h", i, dout[i], mem_fn(16'h0010 + 16'(i)));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int rd0;
        do_reset();
        t0  = cyc;
        rd0 = rd_cnt;
        addr[0]       = 16'h0100;
        rv[0]         = 1'b1;
        rereq_left[0] = 2;
        push(0, mem_fn(16'h0100), t0 + 4);
        repeat (20) tick();
        total++;
        if (rd_cnt - rd0 != 3) begin
            bad++;
            $display("FAIL b2b_issue_count: got %0d want 3", rd_cnt - rd0);
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending: got %0d outstanding want 0", expq.size());
        end
    endtask

    task automatic test_stall();
        int s;
        do_reset();
        mem_ready = 1'b0;
        addr[3]   = 16'h3333;
        rv[3]     = 1'b1;
        push(3, mem_fn(16'h3333), cyc + 9);
        for (int c = 0; c < 5; c++) begin
            total++;
            if (mem_rd !== 1'b0 || dut.r_rr_ptr !== 2'd0) begin
                bad++;
                $display("FAIL stall_hold cycle %0d: got rd=%b ptr=%0d want rd=0 ptr=0", c, mem_rd, dut.r_rr_ptr);
            end
            tick();
        end
        mem_ready = 1'b1;
        total++;
        if (mem_rd !== 1'b0) begin
            bad++;
            $display("FAIL stall_early: got rd=%b want 0", mem_rd);
        end
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_address !== 16'h3333 || dut.r_rr_ptr !== 2'd0) begin
            bad++;
            $display("FAIL stall_issue: got rd=%b addr=%h ptr=%0d want rd=1 addr=3333 ptr=0",
                     mem_rd, mem_address, dut.r_rr_ptr);
        end
        repeat (5) tick();
        // In-flight spcon read returns on time while bg0 waits out a 3-cycle stall.
        s = cyc;
        addr[0] = 16'h0055;
        rv[0]   = 1'b1;
        push(0, mem_fn(16'h0055), s + 4);
        tick();
        mem_ready = 1'b0;
        addr[1]   = 16'h0066;
        rv[1]     = 1'b1;
        push(1, mem_fn(16'h0066), s + 8);
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_address !== 16'h0066) begin
            bad++;
            $display("FAIL stall_resume: got rd=%b addr=%h want rd=1 addr=0066", mem_rd, mem_address);
        end
        repeat (6) tick();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL stall_pending: got %0d outstanding want 0", expq.size());
        end
    endtask

    task automatic test_fairness();
        int a0;
        int b0;
        int da;
        int db;
        do_reset();
        a0 = cnt_a;
        b0 = cnt_b;
        alt_err   = 0;
        fair_mode = 1'b1;
        timed     = 1'b0;
        addr[0] = 16'h0200;
        addr[2] = 16'h0202;
        rv[0]   = 1'b1;
        rv[2]   = 1'b1;
        rereq_left[0] = 100;
        rereq_left[2] = 100;
        push(0, mem_fn(16'h0200), -1);
        push(2, mem_fn(16'h0202), -1);
        repeat (20) tick();
        rereq_left[0] = 0;
        rereq_left[2] = 0;
        da = cnt_a - a0;
        db = cnt_b - b0;
        total++;
        if (da - db > 1 || db - da > 1 || da < 3 || db < 3) begin
            bad++;
            $display("FAIL fair_counts: got spcon=%0d bg1=%0d want equal within 1, each >= 3", da, db);
        end
        repeat (15) tick();
        fair_mode = 1'b0;
        timed     = 1'b1;
        total++;
        if (alt_err != 0) begin
            bad++;
            $display("FAIL fair_alternate: got %0d repeated grants want 0", alt_err);
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL fair_pending: got %0d outstanding want 0", expq.size());
        end
    endtask

    task automatic test_reset_midflight();
        int t1;
        do_reset();
        addr[2] = 16'h0222;
        rv[2]   = 1'b1;
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_address !== 16'h0222) begin
            bad++;
            $display("FAIL mid_issue: got rd=%b addr=%h want rd=1 addr=0222", mem_rd, mem_address);
        end
        RSTb  = 1'b0;
        rv[2] = 1'b0;
        tick();
        RSTb = 1'b1;
        total++;
        if (mem_rd !== 1'b0 || mem_address !== 16'h0 || rdy !== 4'b0 || dout[0] !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset: got rd=%b addr=%h rdy=%b d0=%h want 0 0000 0000 0000",
                     mem_rd, mem_address, rdy, dout[0]);
        end
        repeat (6) tick();
        total++;
        if (dout[2] !== 16'h0) begin
            bad++;
            $display("FAIL mid_discard: got %h want 0000", dout[2]);
        end
        t1 = cyc;
        addr[2] = 16'h0444;
        rv[2]   = 1'b1;
        push(2, mem_fn(16'h0444), t1 + 4);
        repeat (7) tick();
        total++;
        if (expq.size() != 0 || dout[2] !== mem_fn(16'h0444)) begin
            bad++;
            $display("FAIL mid_after: got %0d outstanding data %h want 0 %h", expq.size(), dout[2], mem_fn(16'h0444));
        end
    endtask

    initial begin
        RSTb      = 1'b0;
        mem_ready = 1'b1;
        rv        = 4'b0;
        timed     = 1'b1;
        fair_mode = 1'b0;
        prev_rv   = 4'b0;
        prev_rdy  = 4'b0;
        prev_rst  = 1'b0;
        last_rd_addr = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i]       = '0;
            rereq_left[i] = 0;
        end
        test_reset();
        test_single();
        test_all_ports();
        test_back_to_back();
        test_stall();
        test_fairness();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
